imem_loader: RTL

Parametrised instruction-memory boot loader and core-reset sequencer for the RV32I microprocessor. It replaces the raw `en`/`instruction` program-load path with a valid/ready word stream, configurable word width and memory depth, and length checking. It holds the core in reset until the program has been written, then releases the core. It sits between the external programming port and the instruction memory write port, and drives the core's reset.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_loader_csum.sv | 28 ++
 rtl/imem_loader.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory boot loader:
// FSM state encoding and the load-length legality check.
package imem_loader_pkg;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_LOAD_ENC  = 2'd1;
    localparam logic [1:0] ST_FLUSH_ENC = 2'd2;
    localparam logic [1:0] ST_RUN_ENC   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_LOAD  = ST_LOAD_ENC,
        ST_FLUSH = ST_FLUSH_ENC,
        ST_RUN   = ST_RUN_ENC
    } state_t;

    // A session must write at least one word and never past the end of memory.
    function automatic logic len_ok(input int unsigned len, input int unsigned depth);
        return (len != 0) && (len <= depth);
    endfunction

endpackage

// File: rtl/imem_loader_csum.sv
// Running modulo-2^XLEN sum of accepted program words; only built when
// IMEM_LOADER_CSUM_EN is defined.
module imem_loader_csum #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            add_en,
    input  logic [XLEN-1:0] add_data,
    output logic [XLEN-1:0] sum
);

    logic [XLEN-1:0] sum_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg <= '0;
        end else if (clear) begin
            sum_reg <= '0;
        end else if (add_en) begin
            sum_reg <= sum_reg + add_data;
        end
    end

    assign sum = sum_reg;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory boot loader: streams words into imem over valid/ready and
// holds the core in reset until the image is written. Optional checksum gate
// via IMEM_LOADER_CSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
`ifdef IMEM_LOADER_CSUM_EN
    input  logic [XLEN-1:0] exp_csum,
`endif
    input  logic            clk,
    input  logic            rst,
    input  logic            load_start,
    input  logic [AW:0]     load_len,
    input  logic            load_abort,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_data,
    output logic            in_ready,
    output logic            imem_we,
    output logic [AW-1:0]   imem_addr,
    output logic [XLEN-1:0] imem_wdata,
    output logic            core_rst,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int unsigned DEPTH_U = DEPTH;

    state_t          state_reg, state_next;
    logic [AW-1:0]   cnt_reg, cnt_next;
    logic [AW:0]     len_reg, len_next;
    logic [AW:0]     len_m1;
    logic            in_ready_reg, in_ready_next;
    logic            we_reg, we_next;
    logic [AW-1:0]   addr_reg, addr_next;
    logic [XLEN-1:0] wdata_reg, wdata_next;
    logic            core_rst_reg, core_rst_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            err_reg, err_next;
    logic            start_ok;
    logic            xfer;
    logic            csum_bad;

    assign start_ok = len_ok(32'(load_len), DEPTH_U);
    assign len_m1   = len_reg - {{AW{1'b0}}, 1'b1};
    // Abort wins over a handshake in the same cycle, so the word is dropped.
    assign xfer     = (state_reg == ST_LOAD) && in_ready_reg && in_valid && !load_abort;

`ifdef IMEM_LOADER_CSUM_EN
    logic            csum_clear;
    logic [XLEN-1:0] csum_sum;

    assign csum_clear = (state_next == ST_LOAD) && (state_reg != ST_LOAD);

    imem_loader_csum #(
        .XLEN(XLEN)
    ) u_csum (
        .clk      (clk),
        .rst      (rst),
        .clear    (csum_clear),
        .add_en   (xfer),
        .add_data (in_data),
        .sum      (csum_sum)
    );

    assign csum_bad = (csum_sum != exp_csum);
`else
    assign csum_bad = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        len_next   = len_reg;
        we_next    = 1'b0;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;

        case (state_reg)
            ST_IDLE, ST_RUN: begin
                if (load_start) begin
                    if (start_ok) begin
                        state_next = ST_LOAD;
                        len_next   = load_len;
                        cnt_next   = '0;
                    end else begin
                        state_next = ST_IDLE;
                        err_next   = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (load_abort) begin
                    state_next = ST_IDLE;
                    err_next   = 1'b1;
                end else if (xfer) begin
                    we_next    = 1'b1;
                    addr_next  = cnt_reg;
                    wdata_next = in_data;
                    if ({1'b0, cnt_reg} == len_m1) begin
                        state_next = ST_FLUSH;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (load_abort || csum_bad) begin
                    state_next = ST_IDLE;
                    err_next   = 1'b1;
                end else begin
                    state_next = ST_RUN;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Status outputs are registered copies of the upcoming state.
        in_ready_next = (state_next == ST_LOAD);
        busy_next     = (state_next == ST_LOAD) || (state_next == ST_FLUSH);
        core_rst_next = (state_next != ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            len_reg      <= '0;
            in_ready_reg <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            core_rst_reg <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            len_reg      <= len_next;
            in_ready_reg <= in_ready_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            core_rst_reg <= core_rst_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    assign in_ready   = in_ready_reg;
    assign imem_we    = we_reg;
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign core_rst   = core_rst_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign err        = err_reg;

endmodule
